// File: rtl/jogo_pkg.sv
// rtl/jogo_pkg.sv - shared state codes, button count and cell decoding for the play detector
package jogo_pkg;

    localparam int N_BOTOES = 9;

    localparam logic [2:0] OCIOSO        = 3'd0;
    localparam logic [2:0] FILTRANDO     = 3'd1;
    localparam logic [2:0] VALIDA        = 3'd2;
    localparam logic [2:0] ESPERA_SOLTAR = 3'd3;

    // Returns the 1-based cell of a one-hot button vector, 0 when zero or multiple bits are set.
    function automatic logic [3:0] onehot_para_posicao(input logic [8:0] v);
        logic [3:0] p;
        p = 4'd0;
        if ($countones(v) == 1) begin
            for (int i = 0; i < 9; i++) begin
                if (v[i]) p = 4'(i + 1);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// rtl/sincronizador_2ff.sv - two-flop synchronizer for asynchronous button inputs
module sincronizador_2ff #(
    parameter int WIDTH = 9
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sinc_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sinc_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q <= '0;
            sinc_q <= '0;
        end else begin
            meta_q <= async_i;
            sinc_q <= meta_q;
        end
    end

    assign sinc_o = sinc_q;

endmodule

// File: rtl/detector_jogada.sv
// rtl/detector_jogada.sv - debounced single-press play detector; DETECTOR_DEBOUNCE_EN enables the D-cycle filter
module detector_jogada
    import jogo_pkg::*;
#(
    parameter int N_BOTOES        = 9,
    parameter int DEBOUNCE_CICLOS = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                habilita,
    input  logic [N_BOTOES-1:0] botoes,
    output logic                jogada_valida,
    output logic                jogada_invalida,
    output logic [3:0]          posicao,
    output logic                tem_jogada,
    output logic [2:0]          db_estado
);

`ifdef DETECTOR_DEBOUNCE_EN
    localparam int D = (DEBOUNCE_CICLOS < 1) ? 1 : DEBOUNCE_CICLOS;
`else
    // Fast build: the parameter stays in the interface but the filter is one cycle.
    localparam int D = 1 + 0 * DEBOUNCE_CICLOS;
`endif
    localparam int CW = (D < 2) ? 1 : $clog2(D + 1);
    localparam logic [CW-1:0] CNT_D   = CW'(D);
    localparam logic [CW-1:0] CNT_UM  = CW'(1);

    logic [N_BOTOES-1:0] sinc;

    sincronizador_2ff #(.WIDTH(N_BOTOES)) u_sinc (
        .clock   (clock),
        .reset   (reset),
        .async_i (botoes),
        .sinc_o  (sinc)
    );

    logic [2:0]          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [N_BOTOES-1:0] amostra_q, amostra_d;
    logic [3:0]          posicao_q, posicao_d;
    logic                valida_q, valida_d;
    logic                invalida_q, invalida_d;
    logic                tem_q;
    logic [3:0]          pos_amostra;

    assign pos_amostra = onehot_para_posicao(amostra_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        amostra_d  = amostra_q;
        posicao_d  = posicao_q;
        valida_d   = 1'b0;
        invalida_d = 1'b0;
        case (state_q)
            OCIOSO: begin
                if (sinc != '0) begin
                    if (habilita) begin
                        amostra_d = sinc;
                        cnt_d     = CNT_UM;
                        state_d   = FILTRANDO;
                    end else begin
                        // A press made while plays are disabled must be released before it can count.
                        cnt_d   = '0;
                        state_d = ESPERA_SOLTAR;
                    end
                end
            end
            FILTRANDO: begin
                if (!habilita) begin
                    cnt_d   = '0;
                    state_d = ESPERA_SOLTAR;
                end else if (sinc == '0) begin
                    cnt_d   = '0;
                    state_d = OCIOSO;
                end else if (sinc != amostra_q) begin
                    amostra_d = sinc;
                    cnt_d     = CNT_UM;
                end else if (cnt_q == CNT_D) begin
                    state_d = VALIDA;
                    if (pos_amostra != 4'd0) begin
                        valida_d  = 1'b1;
                        posicao_d = pos_amostra;
                    end else begin
                        invalida_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_UM;
                end
            end
            VALIDA: begin
                cnt_d   = '0;
                state_d = ESPERA_SOLTAR;
            end
            ESPERA_SOLTAR: begin
                if (sinc != '0) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_D) begin
                    cnt_d   = '0;
                    state_d = OCIOSO;
                end else begin
                    cnt_d = cnt_q + CNT_UM;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= OCIOSO;
            cnt_q      <= '0;
            amostra_q  <= '0;
            posicao_q  <= 4'd0;
            valida_q   <= 1'b0;
            invalida_q <= 1'b0;
            tem_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            amostra_q  <= amostra_d;
            posicao_q  <= posicao_d;
            valida_q   <= valida_d;
            invalida_q <= invalida_d;
            tem_q      <= (state_d != OCIOSO);
        end
    end

    assign jogada_valida   = valida_q;
    assign jogada_invalida = invalida_q;
    assign posicao         = posicao_q;
    assign tem_jogada      = tem_q;
    assign db_estado       = state_q;

endmodule
